// File: rtl/bhg_burst_drain_pkg.sv
// Shared state type and sizing helper for the FIFO burst drain.
package bhg_burst_drain_pkg;

  typedef enum logic {COLLECT, ISSUE} state_t;

  function automatic int IDX_BITS(input int burst_words);
    return $clog2(burst_words);
  endfunction

endpackage

// File: rtl/bhg_burst_flush_timer.sv
// Idle-cycle counter that times out a partially collected burst.
// Only instantiated when BHG_BURST_DRAIN_FLUSH_EN is defined.
module bhg_burst_flush_timer #(
  parameter int flush_cycles = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int CW = $clog2(flush_cycles + 1);
  localparam logic [CW-1:0] LAST = CW'(flush_cycles - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && count != LAST) begin
      count <= count + 1'b1;
    end
  end

  // Fires on the idle edge that brings the count up to flush_cycles.
  assign done = enable && !clear && (count == LAST);

endmodule

// File: rtl/bhg_fifo_burst_drain.sv
// Pops FWFT FIFO words, packs burst_words of them into one DDR3 write command.
// Define BHG_BURST_DRAIN_FLUSH_EN to flush partial bursts after flush_cycles idle cycles.
module bhg_fifo_burst_drain
  import bhg_burst_drain_pkg::*;
#(
  parameter int bits         = 8,
  parameter int burst_words  = 4,
  parameter int addr_bits    = 24,
  parameter int flush_cycles = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fifo_data_ready,
  output logic                        fifo_shift_out,
  input  logic [bits-1:0]             fifo_data,
  input  logic                        cmd_busy,
  output logic                        cmd_ena,
  output logic [addr_bits-1:0]        cmd_addr,
  output logic [bits*burst_words-1:0] cmd_wdata,
  output logic [burst_words-1:0]      cmd_wmask
);

  localparam int IW = IDX_BITS(burst_words);

  if (burst_words < 2 || burst_words > 32 || (burst_words & (burst_words - 1)) != 0) begin : g_bad_burst_words
    $error("burst_words must be a power of two in 2..32");
  end
  if (flush_cycles < 1) begin : g_bad_flush_cycles
    $error("flush_cycles must be at least 1");
  end

  state_t        state;
  logic [IW-1:0] idx;
  logic          pop;
  logic          flush;

  assign pop            = (state == COLLECT) && fifo_data_ready && !reset;
  assign fifo_shift_out = pop;

`ifdef BHG_BURST_DRAIN_FLUSH_EN
  bhg_burst_flush_timer #(
    .flush_cycles(flush_cycles)
  ) u_flush_timer (
    .clk   (clk),
    .reset (reset),
    .clear ((state != COLLECT) || pop),
    .enable((state == COLLECT) && (idx != '0)),
    .done  (flush)
  );
`else
  assign flush = 1'b0;
`endif

  // Slot idx fills on each pop; the last slot or an idle timeout moves to ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= COLLECT;
      idx       <= '0;
      cmd_ena   <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_wmask <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (pop) begin
            for (int i = 0; i < burst_words; i++) begin
              if (idx == IW'(i)) begin
                cmd_wdata[i*bits +: bits] <= fifo_data;
                cmd_wmask[i]              <= 1'b1;
              end
            end
            idx <= idx + 1'b1;
            if (idx == IW'(burst_words - 1)) begin
              state   <= ISSUE;
              cmd_ena <= 1'b1;
            end
          end else if (flush) begin
            state   <= ISSUE;
            cmd_ena <= 1'b1;
          end
        end
        ISSUE: begin
          if (!cmd_busy) begin
            state     <= COLLECT;
            cmd_ena   <= 1'b0;
            cmd_wmask <= '0;
            idx       <= '0;
            cmd_addr  <= cmd_addr + addr_bits'(burst_words);
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_bhg_fifo_burst_drain.sv
// Scoreboard bench for bhg_fifo_burst_drain; a second instance with addr_bits=4 checks address wrap.
module tb_bhg_fifo_burst_drain;

  localparam int BITS = 8;
  localparam int BW   = 4;
  localparam int AB   = 24;
  localparam int FC   = 16;

  typedef struct {
    logic [AB-1:0]      addr;
    logic [BITS*BW-1:0] data;
    logic [BW-1:0]      mask;
  } burst_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               fifo_data_ready = 1'b0;
  logic [BITS-1:0]    fifo_data = '0;
  logic               cmd_busy = 1'b0;
  logic               fifo_shift_out, cmd_ena;
  logic [AB-1:0]      cmd_addr;
  logic [BITS*BW-1:0] cmd_wdata;
  logic [BW-1:0]      cmd_wmask;
  logic               shift4, ena4;
  logic [3:0]         addr4;
  logic [BITS*BW-1:0] wdata4;
  logic [BW-1:0]      wmask4;

  int passes = 0;
  int checks = 0;
  int pops = 0;
  int transfers = 0;

  logic [7:0]         src_q[$];
  burst_t             exp_q[$];
  bit                 feed_en = 1'b0;
  logic [AB-1:0]      next_addr = '0;
  logic [BITS*BW-1:0] pend_data = '0;
  int                 pend_n = 0;

  bhg_fifo_burst_drain #(.bits(BITS), .burst_words(BW), .addr_bits(AB), .flush_cycles(FC)) dut (
    .clk(clk), .reset(reset), .fifo_data_ready(fifo_data_ready), .fifo_shift_out(fifo_shift_out),
    .fifo_data(fifo_data), .cmd_busy(cmd_busy), .cmd_ena(cmd_ena), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask));

  bhg_fifo_burst_drain #(.bits(BITS), .burst_words(BW), .addr_bits(4), .flush_cycles(FC)) dut4 (
    .clk(clk), .reset(reset), .fifo_data_ready(fifo_data_ready), .fifo_shift_out(shift4),
    .fifo_data(fifo_data), .cmd_busy(cmd_busy), .cmd_ena(ena4), .cmd_addr(addr4),
    .cmd_wdata(wdata4), .cmd_wmask(wmask4));

  always #5 clk = ~clk;

  task automatic refresh_fifo();
    fifo_data_ready = feed_en && (src_q.size() != 0);
    fifo_data       = (src_q.size() != 0) ? src_q[0] : '0;
  endtask

  // Upstream FWFT FIFO model: drop the head word on every edge the DUT pops.
  always begin
    @(posedge clk);
    if (fifo_shift_out) begin
      void'(src_q.pop_front());
      pops++;
    end
    #1 refresh_fifo();
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_words(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      logic [7:0] w;
      w = base + 8'(i * 17);
      src_q.push_back(w);
      pend_data[pend_n*BITS +: BITS] = w;
      pend_n++;
      if (pend_n == BW) begin
        exp_q.push_back('{addr: next_addr, data: pend_data, mask: '1});
        next_addr = next_addr + AB'(BW);
        pend_n    = 0;
      end
    end
    refresh_fifo();
  endtask

  task automatic do_reset();
    step();
    reset    = 1'b1;
    feed_en  = 1'b0;
    cmd_busy = 1'b0;
    src_q.delete();
    refresh_fifo();
    step();
    step();
    reset     = 1'b0;
    next_addr = '0;
    pend_n    = 0;
    pend_data = '0;
  endtask

  // Scoreboard: a transfer happens on the next edge whenever cmd_ena is high and busy is low.
  logic [BITS*BW-1:0] bytemask;
  burst_t             e;
  always @(negedge clk) begin
    if (cmd_ena && fifo_shift_out) begin
      checks++;
      $display("[TB] FAIL pop_during_issue shift_out=%0b required 0", fifo_shift_out);
    end
    if (cmd_ena && !cmd_busy) begin
      transfers++;
      checks++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL unexpected_burst addr=%h data=%h mask=%b required none", cmd_addr, cmd_wdata, cmd_wmask);
      end else begin
        e = exp_q.pop_front();
        for (int i = 0; i < BW; i++) bytemask[i*BITS +: BITS] = {BITS{e.mask[i]}};
        if (cmd_addr !== e.addr || (cmd_wdata & bytemask) !== (e.data & bytemask) || cmd_wmask !== e.mask)
          $display("[TB] FAIL burst addr=%h data=%h mask=%b required addr=%h data=%h mask=%b",
                   cmd_addr, cmd_wdata, cmd_wmask, e.addr, e.data, e.mask);
        else passes++;
        checks++;
        if (!ena4 || addr4 !== e.addr[3:0] || wmask4 !== e.mask)
          $display("[TB] FAIL narrow_addr ena=%0b addr=%h mask=%b required ena=1 addr=%h mask=%b",
                   ena4, addr4, wmask4, e.addr[3:0], e.mask);
        else passes++;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    src_q.push_back(8'hAA);
    feed_en = 1'b1;
    refresh_fifo();
    @(negedge clk);
    checks++;
    if (fifo_shift_out !== 1'b0) $display("[TB] FAIL reset_shift_out got=%b required 0", fifo_shift_out); else passes++;
    checks++;
    if (cmd_ena !== 1'b0) $display("[TB] FAIL reset_cmd_ena got=%b required 0", cmd_ena); else passes++;
    checks++;
    if (cmd_addr !== '0) $display("[TB] FAIL reset_cmd_addr got=%h required 0", cmd_addr); else passes++;
    checks++;
    if (cmd_wdata !== '0) $display("[TB] FAIL reset_cmd_wdata got=%h required 0", cmd_wdata); else passes++;
    checks++;
    if (cmd_wmask !== '0) $display("[TB] FAIL reset_cmd_wmask got=%b required 0", cmd_wmask); else passes++;
    do_reset();
  endtask

  task automatic test_single_burst();
    int start;
    do_reset();
    start = transfers;
    push_words(4, 8'h11);
    feed_en = 1'b1;
    refresh_fifo();
    for (int c = 0; c < 40 && transfers == start; c++) step();
    checks++;
    if (transfers != start + 1) $display("[TB] FAIL single_burst_timeout transfers=%0d required %0d", transfers - start, 1);
    else passes++;
    checks++;
    if (cmd_ena !== 1'b0 || cmd_addr !== AB'(4) || cmd_wmask !== '0)
      $display("[TB] FAIL after_transfer ena=%b addr=%h mask=%b required ena=0 addr=4 mask=0", cmd_ena, cmd_addr, cmd_wmask);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int start, start_pops, cycles;
    do_reset();
    start      = transfers;
    start_pops = pops;
    push_words(12, 8'h01);
    feed_en = 1'b1;
    refresh_fifo();
    cycles = 0;
    while (cycles < 60 && transfers < start + 3) begin
      step();
      cycles++;
    end
    checks++;
    if (cycles != 3 * (BW + 1)) $display("[TB] FAIL back_to_back_cycles got=%0d required %0d", cycles, 3 * (BW + 1));
    else passes++;
    checks++;
    if (pops - start_pops != 12 || src_q.size() != 0)
      $display("[TB] FAIL back_to_back_pops got=%0d left=%0d required 12 left=0", pops - start_pops, src_q.size());
    else passes++;
  endtask

  task automatic test_busy_hold();
    burst_t held;
    int     start;
    do_reset();
    cmd_busy = 1'b1;
    push_words(4, 8'hA0);
    held = exp_q[exp_q.size() - 1];
    push_words(4, 8'hC3);
    feed_en = 1'b1;
    refresh_fifo();
    for (int c = 0; c < 20 && !cmd_ena; c++) step();
    start = transfers;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (cmd_ena !== 1'b1 || fifo_shift_out !== 1'b0)
        $display("[TB] FAIL busy_hold_ctrl cycle=%0d ena=%b shift=%b required ena=1 shift=0", c, cmd_ena, fifo_shift_out);
      else passes++;
      checks++;
      if (cmd_wdata !== held.data || cmd_addr !== held.addr || cmd_wmask !== held.mask)
        $display("[TB] FAIL busy_hold_payload cycle=%0d data=%h addr=%h required data=%h addr=%h",
                 c, cmd_wdata, cmd_addr, held.data, held.addr);
      else passes++;
      step();
    end
    cmd_busy = 1'b0;
    step();
    checks++;
    if (transfers != start + 1 || cmd_ena !== 1'b0)
      $display("[TB] FAIL busy_release transfers=%0d ena=%b required 1 ena=0", transfers - start, cmd_ena);
    else passes++;
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) step();
  endtask

  task automatic test_reset_mid_burst();
    int start_pops;
    do_reset();
    start_pops = pops;
    src_q.push_back(8'h5A);
    src_q.push_back(8'h6B);
    src_q.push_back(8'h7C);
    feed_en = 1'b1;
    refresh_fifo();
    for (int c = 0; c < 20 && pops < start_pops + 3; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    src_q.delete();
    refresh_fifo();
    @(negedge clk);
    checks++;
    if (cmd_ena !== 1'b0 || cmd_wmask !== '0 || cmd_addr !== '0)
      $display("[TB] FAIL mid_burst_reset ena=%b mask=%b addr=%h required 0 0 0", cmd_ena, cmd_wmask, cmd_addr);
    else passes++;
    next_addr = '0;
    pend_n    = 0;
    push_words(4, 8'h90);
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) step();
  endtask

  task automatic test_addr_wrap();
    do_reset();
    push_words(24, 8'h20);
    feed_en = 1'b1;
    refresh_fifo();
    for (int c = 0; c < 80 && exp_q.size() != 0; c++) step();
    step();
    checks++;
    if (cmd_addr !== AB'(24) || addr4 !== 4'd8)
      $display("[TB] FAIL addr_wrap wide=%h narrow=%h required wide=18 narrow=8", cmd_addr, addr4);
    else passes++;
  endtask

`ifdef BHG_BURST_DRAIN_FLUSH_EN
  task automatic test_flush();
    int start_pops, idle;
    do_reset();
    start_pops = pops;
    push_words(2, 8'h11);
    exp_q.push_back('{addr: next_addr, data: pend_data, mask: 4'b0011});
    next_addr = next_addr + AB'(BW);
    pend_n    = 0;
    feed_en = 1'b1;
    refresh_fifo();
    for (int c = 0; c < 20 && pops < start_pops + 2; c++) step();
    idle = 0;
    while (idle < 40 && !cmd_ena) begin
      step();
      idle++;
    end
    checks++;
    if (idle != FC || cmd_wmask !== 4'b0011)
      $display("[TB] FAIL flush_timing idle=%0d mask=%b required %0d mask=0011", idle, cmd_wmask, FC);
    else passes++;
    push_words(4, 8'h40);
    refresh_fifo();
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_busy_hold();
    test_reset_mid_burst();
    test_addr_wrap();
`ifdef BHG_BURST_DRAIN_FLUSH_EN
    test_flush();
`endif
    step();
    checks++;
    if (exp_q.size() != 0) $display("[TB] FAIL bursts_outstanding got=%0d required 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bhg_fifo_burst_drain.md
# bhg_fifo_burst_drain

Read-side consumer for the shifter FWFT FIFOs: pops words from an upstream FWFT FIFO (data_ready/shift_out/data_out), packs `burst_words` words into one wide write burst, and issues it to the DDR3 write-command port with a busy/enable handshake and an auto-incrementing word address. It sits between a write-data FIFO and the DDR3 controller's command input.

## Interface
- `bits`, 8, width of one FIFO word.
- `burst_words`, 4, words per burst; power of two, 2..32.
- `addr_bits`, 24, width of the word address.
- `flush_cycles`, 16, idle cycles before a partial burst is flushed (used only with the flush macro); must be ≥1.
- `clk`  in  1  system clock, all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fifo_data_ready`  in  1  upstream FWFT FIFO has a valid word.
- `fifo_shift_out`  out  1  pops the upstream word this cycle.
- `fifo_data`  in  bits  upstream FWFT data_out.
- `cmd_busy`  in  1  DDR3 port cannot accept a command this cycle.
- `cmd_ena`  out  1  burst command valid.
- `cmd_addr`  out  addr_bits  word address of slot 0 of the burst.
- `cmd_wdata`  out  bits*burst_words  packed burst; slot i at bits [i*bits +: bits].
- `cmd_wmask`  out  burst_words  bit i high = slot i holds valid data.

## Operation
- Two states: COLLECT, ISSUE. Reset enters COLLECT.
- COLLECT: `fifo_shift_out = fifo_data_ready` (combinational, no register). On each pop: slot[idx] <= fifo_data, wmask[idx] <= 1, idx <= idx+1.
- Pop that fills slot `burst_words-1` → ISSUE next cycle; idx wraps to 0.
- ISSUE: `fifo_shift_out = 0`; `cmd_ena = 1`, `cmd_addr`/`cmd_wdata`/`cmd_wmask` stable. Transfer occurs on the edge where `cmd_ena && !cmd_busy`; then wmask <= 0, cmd_addr <= cmd_addr + burst_words (modulo 2^addr_bits, wrap silently), state → COLLECT.
- cmd_wdata is not cleared after a transfer; unused slots are don't-care, qualified by cmd_wmask.
- `cmd_busy` is ignored outside ISSUE; `fifo_data` is ignored when no pop occurs.
- Reset mid-burst: collected words are discarded, not issued; the upstream FIFO is reset separately.

## Timing
- Reset values: `fifo_shift_out` 0 (while reset is asserted), `cmd_ena` 0, `cmd_addr` 0, `cmd_wdata` 0, `cmd_wmask` 0, idx 0, flush timer 0.
- Latency: last word popped on edge N → `cmd_ena` high from cycle N+1; earliest transfer on edge N+1.
- Max throughput: burst_words pops + 1 issue cycle per burst (burst_words+1 cycles).
- `cmd_busy` held high: `cmd_ena` and payload hold indefinitely; no pops occur.
- `cmd_ena` deasserts in the cycle after the transfer edge; a pop can occur in that same cycle.

## Configuration
- `BHG_BURST_DRAIN_FLUSH_EN` defined: in COLLECT with idx>0, an idle counter increments each cycle without a pop and clears on a pop. When it reaches `flush_cycles`, the block enters ISSUE with a partial mask (e.g. 0011). After the transfer, cmd_addr still advances by burst_words, idx clears to 0, and the counter clears.
- Not defined: no counter is built; only full bursts are issued, and a partial burst waits indefinitely.

## Structure
- Package `bhg_burst_drain_pkg`: state enum (COLLECT, ISSUE) and the helper function `IDX_BITS = $clog2(burst_words)`.
- One sub-module, `bhg_burst_flush_timer`: idle counter with clear/enable/terminal-count output. It is instantiated only under the macro.

## Test plan
- bits=8, burst_words=4, reset release, FIFO feeds 0x11,0x22,0x33,0x44 back-to-back, cmd_busy=0 → one cmd_ena pulse, cmd_wdata=0x44332211, wmask=1111, addr=0; next addr=4.
- Continuous 12-word stream → three bursts at addr 0,4,8; exactly one dead pop cycle per burst; no words lost or reordered.
- cmd_busy high for 10 cycles during ISSUE → cmd_ena and payload stable for 10 cycles, fifo_shift_out=0 throughout, transfer on the first edge with busy low.
- addr_bits=4: four bursts starting from addr 8 → addresses 8, 12, 0, 4 (wrap).
- Macro defined, flush_cycles=16, 2 words then FIFO empty → ISSUE 16 idle cycles after the last pop, wmask=0011; next burst addr=4.
- Assert reset for 1 cycle after 3 words collected → cmd_ena stays 0, wmask=0, addr=0; next full burst is correct.
